// File: rtl/nms_scan_controller_pkg.sv
// Shared types and frame-size defaults for the NMS scan controller and its helpers.
package nms_scan_controller_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/nms_scan_controller_if.sv
// Pixel-in / window-out handshake bundle between the NMS scan controller and its neighbours.
interface nms_scan_controller_if
    import nms_scan_controller_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          shift_en;
    logic          pad;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          border;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          frame_done;

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, shift_en, pad, win_valid, win_row, win_col,
               border, sof, eol, eof, busy, frame_done
    );

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, shift_en, pad, win_valid, win_row, win_col,
               border, sof, eol, eof, busy, frame_done
    );

endinterface

// File: rtl/nms_scan_controller_coord_counter.sv
// Raster-order row/column counter: column wraps at COLS-1 and bumps the row, row wraps at ROWS-1.
module nms_coord_counter #(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_clr,
    output logic [$clog2(ROWS)-1:0] o_row,
    output logic [$clog2(COLS)-1:0] o_col,
    output logic                    o_last
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_row_end;
    logic          w_col_end;

    assign w_row_end = (r_row == RW'(ROWS - 1));
    assign w_col_end = (r_col == CW'(COLS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_row_end & w_col_end;

endmodule

// File: rtl/nms_scan_controller.sv
// Sequences a 3x3 NMS window over a raster frame: fills the line buffers, presents one window per
// accepted pixel, then pads out the tail so every pixel gets exactly one centred window.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | priming line buffers with the first IMG_W+1 pixels, no windows yet
// RUN   | one window per accepted pixel, back-pressured by out_ready
// FLUSH | shifting zeros to push out the last IMG_W+1 windows
// DONE  | single-cycle frame_done pulse
module nms_scan_controller
    import nms_scan_controller_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input logic                  clk,
    input logic                  rst,
    nms_scan_controller_if.slave bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic          r_win_valid;

    logic [RW-1:0] w_in_row;
    logic [CW-1:0] w_in_col;
    logic          w_in_last;
    logic [RW-1:0] w_win_row;
    logic [CW-1:0] w_win_col;
    logic          w_win_last;

    logic          w_in_ready;
    logic          w_shift;
    logic          w_pad;
    logic          w_slot;
    logic          w_consume;
    logic          w_win_shift;
    logic          w_fill_last;
    logic          w_pad_done;
    logic          w_clr;

    assign w_slot      = ~r_win_valid | bus.out_ready;
    assign w_consume   = r_win_valid & bus.out_ready;
    assign w_fill_last = (w_in_row == RW'(1)) && (w_in_col == '0);
    // The input counter wraps to (0,0) entering FLUSH; (1,1) means IMG_W+1 pad shifts are done.
    assign w_pad_done  = (w_in_row == RW'(1)) && (w_in_col == CW'(1));
    assign w_clr       = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_shift     = 1'b0;
        w_pad       = 1'b0;
        w_win_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                w_in_ready = 1'b1;
                w_shift    = bus.in_valid;
                if (bus.in_valid && w_fill_last) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_in_ready  = w_slot;
                w_shift     = w_slot & bus.in_valid;
                w_win_shift = w_shift;
                if (w_shift && w_in_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!w_pad_done) begin
                    w_shift     = w_slot;
                    w_pad       = w_slot;
                    w_win_shift = w_slot;
                end else if (w_consume) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid <= 1'b0;
        end else if (w_win_shift) begin
            r_win_valid <= 1'b1;
        end else if (w_consume) begin
            r_win_valid <= 1'b0;
        end
    end

    nms_coord_counter #(.ROWS(IMG_H), .COLS(IMG_W)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift),
        .i_clr  (w_clr),
        .o_row  (w_in_row),
        .o_col  (w_in_col),
        .o_last (w_in_last)
    );

    nms_coord_counter #(.ROWS(IMG_H), .COLS(IMG_W)) u_win_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_consume),
        .i_clr  (w_clr),
        .o_row  (w_win_row),
        .o_col  (w_win_col),
        .o_last (w_win_last)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.shift_en   = w_shift;
    assign bus.pad        = w_pad;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_row    = w_win_row;
    assign bus.win_col    = w_win_col;
    assign bus.border     = r_win_valid & ((w_win_row == '0) || (w_win_row == RW'(IMG_H - 1)) ||
                                           (w_win_col == '0) || (w_win_col == CW'(IMG_W - 1)));
    assign bus.sof        = r_win_valid & (w_win_row == '0) & (w_win_col == '0);
    assign bus.eol        = r_win_valid & (w_win_col == CW'(IMG_W - 1));
    assign bus.eof        = r_win_valid & w_win_last;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_nms_scan_controller.sv
// Directed bench for nms_scan_controller on a 4x3 frame: window order, markers, back-pressure,
// throttled input, mid-frame reset and stray start requests.
module tb_nms_scan_controller;

    localparam int W = 4;
    localparam int H = 3;

    localparam int MODE_CONT  = 0;
    localparam int MODE_HOLD  = 1;
    localparam int MODE_TOG   = 2;
    localparam int MODE_START = 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    nms_scan_controller_if #(.IMG_W(W), .IMG_H(H)) bus ();

    nms_scan_controller #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {bus.in_ready, bus.shift_en, bus.pad, bus.win_valid, bus.border, bus.sof,
                bus.eol, bus.eof, bus.busy, bus.frame_done, |bus.win_row, |bus.win_col};
    endfunction

    task automatic run_frame(input int mode, input string tag);
        int exp_r, exp_c, win_n, plain_sh, pad_sh, done_n, eof_cyc, done_cyc, hold_left, first_sh;
        bit held, seen_win, stop;
        exp_r = 0; exp_c = 0; win_n = 0; plain_sh = 0; pad_sh = 0; done_n = 0;
        eof_cyc = -1; done_cyc = -1; hold_left = 0; first_sh = -1;
        held = 0; seen_win = 0; stop = 0;
        for (int cyc = 0; cyc < 300 && !stop; cyc++) begin
            bus.start     = (cyc == 0) || (mode == MODE_START && cyc == 10);
            bus.in_valid  = (mode == MODE_TOG) ? (cyc % 2 == 0) : 1'b1;
            bus.out_ready = 1'b1;
            #1;
            if (mode == MODE_HOLD && !held && bus.win_valid && bus.win_row == 1 && bus.win_col == 1) begin
                held = 1;
                hold_left = 3;
            end
            if (hold_left > 0) begin
                bus.out_ready = 1'b0;
                hold_left--;
                #1;
                chk({tag, " hold in_ready"}, 32'(bus.in_ready), 0);
                chk({tag, " hold shift_en"}, 32'(bus.shift_en), 0);
            end
            if (bus.win_valid) begin
                if (!seen_win) begin
                    seen_win = 1;
                    first_sh = plain_sh;
                end
                chk({tag, " win_row"}, 32'(bus.win_row), 32'(exp_r));
                chk({tag, " win_col"}, 32'(bus.win_col), 32'(exp_c));
                if (bus.out_ready) begin
                    chk({tag, " border"}, 32'(bus.border), 32'(!(exp_r == 1 && (exp_c == 1 || exp_c == 2))));
                    chk({tag, " sof"}, 32'(bus.sof), 32'(exp_r == 0 && exp_c == 0));
                    chk({tag, " eol"}, 32'(bus.eol), 32'(exp_c == 3));
                    chk({tag, " eof"}, 32'(bus.eof), 32'(exp_r == 2 && exp_c == 3));
                    if (exp_r == 2 && exp_c == 3) eof_cyc = cyc;
                    win_n++;
                    if (exp_c == 3) begin
                        exp_c = 0;
                        exp_r = (exp_r == 2) ? 0 : exp_r + 1;
                    end else begin
                        exp_c++;
                    end
                end
            end else if (bus.busy) begin
                chk({tag, " idle border"}, 32'(bus.border), 0);
            end
            if (bus.shift_en) begin
                if (bus.pad) pad_sh++;
                else plain_sh++;
            end
            if (bus.frame_done) begin
                done_n++;
                done_cyc = cyc;
            end
            @(negedge clk);
            if (done_n > 0 && cyc >= done_cyc + 3) stop = 1;
        end
        chk({tag, " frame finished in budget"}, 32'(stop), 1);
        chk({tag, " shifts before first window"}, 32'(first_sh), 6);
        chk({tag, " windows"}, 32'(win_n), 12);
        chk({tag, " pixel shifts"}, 32'(plain_sh), 12);
        chk({tag, " pad shifts"}, 32'(pad_sh), 5);
        chk({tag, " frame_done count"}, 32'(done_n), 1);
        chk({tag, " frame_done after eof"}, 32'(done_cyc - eof_cyc), 1);
        #1;
        chk({tag, " busy after frame"}, 32'(bus.busy), 0);
        @(negedge clk);
    endtask

    task automatic reset_mid();
        int plain_sh, done_n;
        plain_sh = 0;
        done_n = 0;
        for (int cyc = 0; cyc < 40 && plain_sh < 7; cyc++) begin
            bus.start     = (cyc == 0);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            if (bus.shift_en) plain_sh++;
            @(negedge clk);
        end
        chk("rst reached pixel 7", 32'(plain_sh), 7);
        #2;
        rst = 1'b0;
        #1;
        chk("rst mid-frame outputs", 32'(all_outs()), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.start = 1'b0;
            #1;
            if (bus.frame_done) done_n++;
            @(negedge clk);
        end
        chk("rst no frame_done", 32'(done_n), 0);
        chk("rst idle after release", 32'(bus.busy), 0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset outputs", 32'(all_outs()), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_frame(MODE_CONT,  "cont");
        run_frame(MODE_HOLD,  "hold");
        run_frame(MODE_TOG,   "toggle");
        reset_mid();
        run_frame(MODE_CONT,  "after_rst");
        run_frame(MODE_START, "start_in_run");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/nms_scan_controller.md
NMS_SCAN_CONTROLLER -- requirements
Module: nms_scan_controller

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per row (min 3).
REQ-002 SHALL have parameter IMG_H, default 480, meaning rows per frame (min 3).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port start  input  1  single-cycle frame start request, sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  upstream gradient pixel valid.
REQ-007 SHALL have port in_ready  output  1  controller accepts the pixel this cycle.
REQ-008 SHALL have port out_ready  input  1  downstream NMS result consumer ready.
REQ-009 SHALL have port shift_en  output  1  advance line buffers and 3x3 window by one pixel.
REQ-010 SHALL have port pad  output  1  with shift_en, shift in zero instead of input pixel.
REQ-011 SHALL have port win_valid  output  1  window centred on (win_row, win_col) is presented.
REQ-012 SHALL have port win_row  output  clog2(IMG_H)  centre row of presented window.
REQ-013 SHALL have port win_col  output  clog2(IMG_W)  centre column of presented window.
REQ-014 SHALL have port border  output  1  centre on frame border; NMS result forced to 0.
REQ-015 SHALL have port sof, eol, eof  output  1 each  first window / last column / last window markers, qualified by win_valid.
REQ-016 SHALL have port busy  output  1  state not IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after last window is consumed.

Function
REQ-018 SHALL implement states IDLE, FILL, RUN, FLUSH, DONE.
REQ-019 IDLE -> FILL when start=1; start in any other state SHALL be ignored.
REQ-020 FILL: in_ready=1; each accepted pixel SHALL assert shift_en same cycle; after IMG_W+1 accepted pixels -> RUN; win_valid stays 0.
REQ-021 RUN: in_ready = in_valid-independent and equal to (!win_valid | out_ready); accepted pixel SHALL assert shift_en same cycle.
REQ-022 Each shift_en in RUN/FLUSH SHALL set win_valid=1 on the next cycle with the next raster-order centre coordinate; win_valid and coordinates SHALL hold stable until out_ready=1.
REQ-023 win_valid with out_ready=1 and no new shift SHALL clear win_valid next cycle.
REQ-024 Centre coordinate SHALL equal accepted-pixel index minus (IMG_W+1), in raster order, col wrapping IMG_W-1 -> 0 with row increment.
REQ-025 After IMG_W*IMG_H accepted pixels -> FLUSH; in_ready=0 in FLUSH, DONE, IDLE.
REQ-026 FLUSH: shift_en=pad=1 whenever (!win_valid | out_ready); after IMG_W+1 pad shifts and the final window consumed -> DONE.
REQ-027 DONE SHALL last one cycle with frame_done=1, then -> IDLE.
REQ-028 border=1 iff win_row in {0, IMG_H-1} or win_col in {0, IMG_W-1}.
REQ-029 sof=1 for centre (0,0); eol=1 for win_col=IMG_W-1; eof=1 for (IMG_H-1, IMG_W-1).
REQ-030 Exactly IMG_W*IMG_H windows SHALL be presented per frame; no window dropped or duplicated under any out_ready pattern.
REQ-031 in_valid=0 in FILL/RUN SHALL produce no shift and no state change.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, all counters 0, and in_ready, shift_en, pad, win_valid, border, sof, eol, eof, busy, frame_done, win_row, win_col to 0.
REQ-033 rst asserted mid-frame SHALL abandon the frame; no frame_done SHALL be produced.

Structure
REQ-034 State encoding and shared IMG_W/IMG_H defaults SHALL live in the shared canny package.
REQ-035 One sub-module, nms_coord_counter (raster row/col counter with wrap and enable), SHALL be instantiated for input count and centre coordinate.

Verification (IMG_W=4, IMG_H=3)
REQ-036 start, 12 pixels continuous, out_ready=1 -> 5 FILL shifts, 12 windows (0,0)..(2,3), 5 pad shifts, frame_done one cycle after eof window.
REQ-037 out_ready=0 for 3 cycles on window (1,1) -> window held stable, in_ready=0, no shift, resumes with (1,2).
REQ-038 in_valid toggling 1/0 every cycle -> identical window sequence and border pattern; border=0 only for (1,1),(1,2).
REQ-039 rst=0 at pixel 7 -> all outputs 0 immediately; new start yields complete fresh frame with sof at (0,0).
REQ-040 start pulsed during RUN -> ignored; exactly 12 windows, one frame_done.
